dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: fixed wait states before each valid access,
// immediate error response for misaligned or out-of-range addresses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            we_q, err_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            req_err, capture, commit;
   logic            acc_we;
   logic [AW-1:0]   acc_idx;
   logic [31:0]     acc_wdata;
   logic [31:0]     mem [DEPTH_WORDS];

   assign req_err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH_WORDS));

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      commit    = 1'b0;
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      case (state)
         IDLE: begin
            // Zero-wait accesses commit straight from the live inputs.
            acc_we    = we;
            acc_idx   = addr[AW+1:2];
            acc_wdata = wdata;
            if (req) begin
               capture = 1'b1;
               if (req_err) begin
                  state_nxt = RESP;
               end else if (WAIT_CYCLES == 0) begin
                  state_nxt = RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = RESP;
               commit    = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         rdata <= 32'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (commit && !acc_we) rdata <= mem[acc_idx];
      end
   end

   // Captured request fields are only consumed after a capture, so they need no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         we_q    <= we;
         idx_q   <= addr[AW+1:2];
         wdata_q <= wdata;
         err_q   <= req_err;
      end
   end

   // NOTE: the memory array is deliberately not reset; reset only blocks a pending commit.
   always_ff @(posedge clk) begin
      if (!reset && commit && acc_we) mem[acc_idx] <= acc_wdata;
   end

   assign ready = (state == RESP);
   assign err   = (state == RESP) && err_q;
   assign busy  = (state != IDLE);

endmodule
